// File: rtl/pspi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pspi_pkg : shared PSPI definitions (FSM encoding, frame overhead, parity) |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package pspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_GUARD  = 2'd3
  } pspi_state_e;

  // Parity and guard bits that follow the data bits of every frame.
  localparam int PSPI_FRAME_OVH = 2;

  localparam logic PSPI_PAR_EVEN = 1'b0;
  localparam logic PSPI_PAR_ODD  = 1'b1;

  // red_xor is ^data; sense selects even (0) or odd (1) parity.
  function automatic logic pspi_par_bit(input logic red_xor, input logic sense);
    return red_xor ^ sense;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pspi_sipo_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pspi_sipo_rx_if : serial line and received-word handshake bundle          |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
interface pspi_sipo_rx_if #(
  parameter int DATA_W = 8
);
  logic              sin;
  logic              cs_n;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_par_err;
  logic              rx_frm_err;
  logic              rx_overrun;
  logic              rx_abort;

  modport master (
    output sin, cs_n, rx_ready,
    input  rx_data, rx_valid, rx_par_err, rx_frm_err, rx_overrun, rx_abort
  );

  modport slave (
    input  sin, cs_n, rx_ready,
    output rx_data, rx_valid, rx_par_err, rx_frm_err, rx_overrun, rx_abort
  );
endinterface
`default_nettype wire

// File: rtl/pspi_sipo_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pspi_sipo_shift : indexed data capture register plus down-counting bit    |
// |                   pointer, stepped by the receiver FSM                    |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
module pspi_sipo_shift #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_sin,
  input  wire logic              i_first,
  input  wire logic              i_bit,
  input  wire logic              i_rearm,
  output logic      [DATA_W-1:0] o_data,
  output logic                   o_cnt_zero,
  output logic                   o_cnt_full
);
  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_CNT_TOP = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_first) begin
        r_data[DATA_W-1] <= i_sin;
        r_cnt            <= c_CNT_TOP - 1'b1;
      end else if (i_bit) begin
        r_data[r_cnt] <= i_sin;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      // Back-to-back frame: next edge carries the MSB, so point at it.
      if (i_rearm) begin
        r_cnt <= c_CNT_TOP;
      end
    end
  end

  assign o_data     = r_data;
  assign o_cnt_zero = (r_cnt == '0);
  assign o_cnt_full = (r_cnt == c_CNT_TOP);

endmodule
`default_nettype wire

// File: rtl/pspi_sipo_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pspi_sipo_rx : PSPI slave receiver, serial in / parallel out with parity  |
// |                check; PSPI_RX_ERRCNT_EN adds a saturating err_cnt port    |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module pspi_sipo_rx
  import pspi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pspi_sipo_rx_if.slave     bus
`ifdef PSPI_RX_ERRCNT_EN
  ,
  output logic      [7:0]   err_cnt
`endif
);
  pspi_state_e       r_state;
  pspi_state_e       w_state_nxt;
  logic              w_first;
  logic              w_bit;
  logic              w_rearm;
  logic              w_par_cap;
  logic              w_guard_cap;
  logic              w_abort;
  logic [DATA_W-1:0] w_word;
  logic              w_cnt_zero;
  logic              w_cnt_full;
  logic              w_par_exp;
  logic              w_par_err;
  logic              w_load;

  logic              r_par_bit;
  logic              r_guard_bit;
  logic              r_cmpl;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;
  logic              r_abort;

  pspi_sipo_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_sin      (bus.sin),
    .i_first    (w_first),
    .i_bit      (w_bit),
    .i_rearm    (w_rearm),
    .o_data     (w_word),
    .o_cnt_zero (w_cnt_zero),
    .o_cnt_full (w_cnt_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_bit       = 1'b0;
    w_rearm     = 1'b0;
    w_par_cap   = 1'b0;
    w_guard_cap = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.cs_n) begin
          w_first     = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.cs_n) begin
          // Pointer still at the MSB after a guard: no bit of a new frame
          // has been taken yet, so this is a normal end of transfer.
          w_abort     = !w_cnt_full;
          w_state_nxt = ST_IDLE;
        end else begin
          w_bit = 1'b1;
          if (w_cnt_zero) begin
            w_state_nxt = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (bus.cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_par_cap   = 1'b1;
          w_state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (bus.cs_n) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_guard_cap = 1'b1;
          w_rearm     = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The completed word is still intact in the capture register on the edge
  // after the guard, even when the next frame's MSB lands on that edge.
  assign w_par_exp = pspi_par_bit(^w_word, ODD_PARITY ? PSPI_PAR_ODD : PSPI_PAR_EVEN);
  assign w_par_err = r_par_bit ^ w_par_exp;
  assign w_load    = r_cmpl && (!r_valid || bus.rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit   <= 1'b0;
      r_guard_bit <= 1'b0;
      r_cmpl      <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_ovr       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_cmpl  <= w_guard_cap;
      r_abort <= w_abort;
      r_ovr   <= r_cmpl && r_valid && !bus.rx_ready;
      if (w_par_cap) begin
        r_par_bit <= bus.sin;
      end
      if (w_guard_cap) begin
        r_guard_bit <= bus.sin;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_perr  <= w_par_err;
        r_ferr  <= r_guard_bit;
      end else if (!r_cmpl && r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_par_err = r_perr;
  assign bus.rx_frm_err = r_ferr;
  assign bus.rx_overrun = r_ovr;
  assign bus.rx_abort   = r_abort;

`ifdef PSPI_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_load && w_par_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pspi_sipo_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pspi_sipo_rx : directed and randomized checks of pspi_sipo_rx against  |
// |                   a frame-level reference model                           |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
module tb_pspi_sipo_rx;
  import pspi_pkg::*;

  localparam int DATA_W     = 8;
  localparam bit ODD_PARITY = 1'b0;
  localparam int FRAME_LEN  = DATA_W + PSPI_FRAME_OVH;

  typedef struct packed {
    logic              s;
    logic              c;
    logic              lst;
    logic              ab;
    logic [DATA_W-1:0] w;
    logic              pe;
    logic              fe;
  } step_t;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pspi_sipo_rx_if #(.DATA_W(DATA_W)) bus ();
`ifdef PSPI_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  pspi_sipo_rx #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef PSPI_RX_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;

  // Reference model: what the consumer should see after each edge.
  logic              m_valid, m_perr, m_ferr, m_ovr, m_abort;
  logic [DATA_W-1:0] m_data;
  int                m_errcnt;
  logic              pend, pend_perr, pend_ferr;
  logic [DATA_W-1:0] pend_word;
  logic              st_perr, st_ferr;
  logic [DATA_W-1:0] st_word;

  function automatic logic exp_perr(input logic [DATA_W-1:0] d, input logic par);
    return par != ((^d) ^ ODD_PARITY);
  endfunction

  function automatic logic frame_bit(input logic [DATA_W-1:0] d, input logic par,
                                     input logic grd, input int i);
    if (i < DATA_W) return d[DATA_W-1-i];
    if (i == DATA_W) return par;
    return grd;
  endfunction

  // One bit clock: drive inputs, take the edge, advance the model.
  task automatic tick(input logic s, input logic c, input logic lst, input logic ab);
    logic r;
    r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.sin      = s;
    bus.cs_n     = c;
    bus.rx_ready = r;
    @(posedge clk);
    #1;
    cyc++;
    m_ovr   = 1'b0;
    m_abort = 1'b0;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0;
      m_errcnt = 0; pend = 1'b0;
    end else begin
      if (pend) begin
        if (!m_valid || r) begin
          m_valid = 1'b1; m_data = pend_word; m_perr = pend_perr; m_ferr = pend_ferr;
          if (pend_perr && m_errcnt < 255) m_errcnt++;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
      pend = lst;
      if (lst) begin
        pend_word = st_word; pend_perr = st_perr; pend_ferr = st_ferr;
      end
      m_abort = ab;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic grd);
    st_word = d;
    st_perr = exp_perr(d, par);
    st_ferr = grd;
    for (int i = 0; i < FRAME_LEN; i++) begin
      tick(frame_bit(d, par, grd, i), 1'b0, 1'(i == FRAME_LEN - 1), 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== '0) begin errors++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
    checks++; if (bus.rx_par_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", bus.rx_par_err); end
    checks++; if (bus.rx_frm_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.rx_frm_err); end
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus.rx_overrun); end
    checks++; if (bus.rx_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b want 0", bus.rx_abort); end
`ifdef PSPI_RX_ERRCNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_cnt); end
`endif
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", bus.rx_valid); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", bus.rx_data); end
    checks++; if ({bus.rx_par_err, bus.rx_frm_err} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {bus.rx_par_err, bus.rx_frm_err}); end
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5) begin errors++; $display("FAIL basic_hold got %b/%h want 1/a5", bus.rx_valid, bus.rx_data); end
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== m_valid) begin errors++; $display("FAIL basic_accept got %b want %b", bus.rx_valid, m_valid); end
  endtask

  task automatic test_parity_frame();
    rdy_mode = 0;
    send_frame(8'h01, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_data !== 8'h01) begin errors++; $display("FAIL perr_data got %h want 01", bus.rx_data); end
    checks++; if (bus.rx_par_err !== 1'b1) begin errors++; $display("FAIL perr_flag got %b want 1", bus.rx_par_err); end
    checks++; if (bus.rx_frm_err !== 1'b0) begin errors++; $display("FAIL perr_ferr got %b want 0", bus.rx_frm_err); end
`ifdef PSPI_RX_ERRCNT_EN
    checks++; if (err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL perr_errcnt got %0d want %0d", err_cnt, m_errcnt); end
`endif
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    rdy_mode = 0;
    send_frame(8'h5F, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({bus.rx_par_err, bus.rx_frm_err} !== 2'b01) begin errors++; $display("FAIL ferr_flags got %b want 01", {bus.rx_par_err, bus.rx_frm_err}); end
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w [3];
    int   rise [$];
    logic prev;
    int   f, i;
    w[0] = 8'h3C; w[1] = 8'hC3; w[2] = 8'hFF;
    rdy_mode = 1;
    prev = bus.rx_valid;
    for (int t = 0; t < 3 * FRAME_LEN + 3; t++) begin
      if (t < 3 * FRAME_LEN) begin
        f = t / FRAME_LEN;
        i = t % FRAME_LEN;
        st_word = w[f]; st_perr = 1'b0; st_ferr = 1'b0;
        tick(frame_bit(w[f], ^w[f], 1'b0, i), 1'b0, 1'(i == FRAME_LEN - 1), 1'b0);
      end else begin
        tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checks++; if (bus.rx_valid !== m_valid) begin errors++; $display("FAIL b2b_valid t=%0d got %b want %b", t, bus.rx_valid, m_valid); end
      if (m_valid) begin
        checks++; if (bus.rx_data !== m_data) begin errors++; $display("FAIL b2b_data t=%0d got %h want %h", t, bus.rx_data, m_data); end
      end
      checks++; if (bus.rx_overrun !== 1'b0 || bus.rx_abort !== 1'b0) begin errors++; $display("FAIL b2b_pulse t=%0d got ovr=%b abort=%b want 0/0", t, bus.rx_overrun, bus.rx_abort); end
      if (bus.rx_valid && !prev) rise.push_back(cyc);
      prev = bus.rx_valid;
    end
    checks++; if (rise.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", rise.size()); end
    for (int k = 1; k < rise.size(); k++) begin
      checks++; if (rise[k] - rise[k-1] != FRAME_LEN) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", rise[k] - rise[k-1], FRAME_LEN); end
    end
  endtask

  task automatic test_overrun();
    rdy_mode = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", bus.rx_overrun); end
    send_frame(8'h22, 1'b0, 1'b0);
    checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got %b want 0", bus.rx_overrun); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", bus.rx_overrun); end
    checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_keep got %h want 11", bus.rx_data); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_overrun !== 1'b0 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
      errors++; $display("FAIL ovr_after got ovr=%b v=%b d=%h want 0/1/11", bus.rx_overrun, bus.rx_valid, bus.rx_data);
    end
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] d;
    rdy_mode = 1;
    d = 8'hB0;
    for (int i = 0; i < 4; i++) tick(d[DATA_W-1-i], 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.rx_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", bus.rx_abort); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.rx_valid); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_abort !== 1'b0) begin errors++; $display("FAIL abort_once got %b want 0", bus.rx_abort); end
    rdy_mode = 0;
    send_frame(8'h5A, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_data !== 8'h5A || bus.rx_par_err !== 1'b0 || bus.rx_valid !== 1'b1) begin
      errors++; $display("FAIL abort_next got d=%h pe=%b v=%b want 5a/0/1", bus.rx_data, bus.rx_par_err, bus.rx_valid);
    end
    d = 8'h33;
    for (int i = 0; i < FRAME_LEN - 1; i++) tick(frame_bit(d, 1'b0, 1'b0, i), 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.rx_abort !== 1'b1) begin errors++; $display("FAIL abort_guard got %b want 1", bus.rx_abort); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || bus.rx_overrun !== 1'b0) begin
      errors++; $display("FAIL abort_held got v=%b d=%h ovr=%b want 1/5a/0", bus.rx_valid, bus.rx_data, bus.rx_overrun);
    end
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [DATA_W-1:0] d;
    rdy_mode = 0;
    send_frame(8'h77, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    d = 8'h99;
    for (int i = 0; i < DATA_W; i++) tick(d[DATA_W-1-i], 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if ({bus.rx_valid, bus.rx_par_err, bus.rx_frm_err, bus.rx_overrun, bus.rx_abort} !== 5'b0) begin
      errors++; $display("FAIL rstmid_flags got %b want 00000", {bus.rx_valid, bus.rx_par_err, bus.rx_frm_err, bus.rx_overrun, bus.rx_abort});
    end
    checks++; if (bus.rx_data !== '0) begin errors++; $display("FAIL rstmid_data got %h want 00", bus.rx_data); end
    send_frame(8'h80, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h80 || bus.rx_par_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_next got v=%b d=%h pe=%b want 1/80/0", bus.rx_valid, bus.rx_data, bus.rx_par_err);
    end
    rdy_mode = 1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    step_t q [$];
    step_t st;
    logic [DATA_W-1:0] d;
    logic par, grd;
    int   p;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) q.push_back('{s: 1'b0, c: 1'b1, lst: 1'b0, ab: 1'b0, w: '0, pe: 1'b0, fe: 1'b0});
      d   = DATA_W'($urandom);
      par = ((^d) ^ ODD_PARITY) ^ ($urandom_range(0, 3) == 0);
      grd = ($urandom_range(0, 7) == 0);
      p   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FRAME_LEN - 1)) : FRAME_LEN;
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (i == p) begin
          q.push_back('{s: 1'b0, c: 1'b1, lst: 1'b0, ab: 1'b1, w: '0, pe: 1'b0, fe: 1'b0});
          break;
        end
        q.push_back('{s: frame_bit(d, par, grd, i), c: 1'b0, lst: 1'(i == FRAME_LEN - 1), ab: 1'b0,
                      w: d, pe: exp_perr(d, par), fe: grd});
      end
    end
    repeat (3) q.push_back('{s: 1'b0, c: 1'b1, lst: 1'b0, ab: 1'b0, w: '0, pe: 1'b0, fe: 1'b0});
    rdy_mode = 2;
    foreach (q[k]) begin
      st = q[k];
      st_word = st.w; st_perr = st.pe; st_ferr = st.fe;
      tick(st.s, st.c, st.lst, st.ab);
      checks++; if (bus.rx_valid !== m_valid) begin errors++; $display("FAIL rnd_valid k=%0d got %b want %b", k, bus.rx_valid, m_valid); end
      checks++; if (bus.rx_data !== m_data) begin errors++; $display("FAIL rnd_data k=%0d got %h want %h", k, bus.rx_data, m_data); end
      checks++; if ({bus.rx_par_err, bus.rx_frm_err} !== {m_perr, m_ferr}) begin errors++; $display("FAIL rnd_flags k=%0d got %b want %b", k, {bus.rx_par_err, bus.rx_frm_err}, {m_perr, m_ferr}); end
      checks++; if (bus.rx_overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr k=%0d got %b want %b", k, bus.rx_overrun, m_ovr); end
      checks++; if (bus.rx_abort !== m_abort) begin errors++; $display("FAIL rnd_abort k=%0d got %b want %b", k, bus.rx_abort, m_abort); end
`ifdef PSPI_RX_ERRCNT_EN
      checks++; if (err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL rnd_errcnt k=%0d got %0d want %0d", k, err_cnt, m_errcnt); end
`endif
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.sin      = 1'b0;
    bus.cs_n     = 1'b1;
    bus.rx_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0;
    m_ovr = 1'b0; m_abort = 1'b0; m_errcnt = 0;
    pend = 1'b0; pend_word = '0; pend_perr = 1'b0; pend_ferr = 1'b0;
    st_word = '0; st_perr = 1'b0; st_ferr = 1'b0;
    test_reset();
    test_basic();
    test_parity_frame();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
